// File: rtl/memory_tank_access_if.sv
// Request/response and tank-gate bundle between a requester (master) and
// the tank access controller (slave). The tank model sits on the master side
// and returns the serial output bus r1_mob.
interface memory_tank_access_if #(parameter int WORD_W = 35);
  logic              r1_req;
  logic              r1_we;
  logic              r1_long;
  logic [4:0]        r1_addr;
  logic [WORD_W-1:0] r1_wdata;
  logic              r1_ack;
  logic              r1_busy;
  logic [WORD_W-1:0] r1_rdata;
  logic              r1_tank_clr;
  logic              r1_tank_in;
  logic              r1_tank_out;
  logic              r1_mib;
  logic              r1_mob;
  logic [4:0]        r1_pulse;
  logic [4:0]        r1_minor;

  modport master (
    output r1_req, r1_we, r1_long, r1_addr, r1_wdata, r1_mob,
    input  r1_ack, r1_busy, r1_rdata, r1_tank_clr, r1_tank_in, r1_tank_out,
           r1_mib, r1_pulse, r1_minor
  );

  modport slave (
    input  r1_req, r1_we, r1_long, r1_addr, r1_wdata, r1_mob,
    output r1_ack, r1_busy, r1_rdata, r1_tank_clr, r1_tank_in, r1_tank_out,
           r1_mib, r1_pulse, r1_minor
  );
endinterface

// File: rtl/memory_tank_access.sv
// Initiator for one mercury-tank store. Tracks circulation position
// (minor, pulse), waits for the addressed word to come round, then shifts it
// in or out LSB-first. Gates are pure decodes of the registered state so an
// asynchronous reset drops them immediately.
module memory_tank_access #(
  parameter int PULSES = 18,
  parameter int MINORS = 32,
  parameter int WORD_W = 35
) (
  input logic                  r1_clk,
  input logic                  r1_rst_n,
  memory_tank_access_if.slave  bus
);
  localparam int SW = (WORD_W - 1) / 2;
  localparam int OW = $clog2(2 * PULSES);

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        pulse_q, minor_q, minor_nx;
  logic [4:0]        addr_in, addr_q;
  logic              we_q, long_q;
  logic [WORD_W-1:0] wdata_q, rd_sh_q, rdata_q;
  logic [OW-1:0]     off_q, last_off;
  logic              pwrap, accept, xfer_last;
  logic              clr, tin, tout, mib;

  assign pwrap     = (pulse_q == 5'(PULSES - 1));
  assign minor_nx  = (minor_q == 5'(MINORS - 1)) ? 5'd0 : minor_q + 5'd1;
  // Long words occupy a minor-cycle pair starting on an even minor.
  assign addr_in   = bus.r1_long ? {bus.r1_addr[4:1], 1'b0} : bus.r1_addr;
  assign accept    = (state_q == IDLE) && bus.r1_req;
  assign last_off  = long_q ? OW'(2 * PULSES - 1) : OW'(PULSES - 1);
  assign xfer_last = (state_q == XFER) && (off_q == last_off);

  // Free-running circulation position.
  always_ff @(posedge r1_clk or negedge r1_rst_n) begin
    if (!r1_rst_n) begin
      pulse_q <= '0;
      minor_q <= '0;
    end else begin
      pulse_q <= pwrap ? 5'd0 : pulse_q + 5'd1;
      if (pwrap) minor_q <= minor_nx;
    end
  end

  // State register.
  always_ff @(posedge r1_clk or negedge r1_rst_n) begin
    if (!r1_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state plus gate decode; XFER is entered on the edge where the
  // position becomes (addr, 0), including the accepting edge itself.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    tin     = 1'b0;
    tout    = 1'b0;
    mib     = 1'b0;
    case (state_q)
      IDLE:      if (bus.r1_req)
                   state_d = (pwrap && minor_nx == addr_in) ? XFER : WAIT_SLOT;
      WAIT_SLOT: if (pwrap && minor_nx == addr_q) state_d = XFER;
      XFER: begin
        if (off_q == last_off) state_d = DONE;
        if (we_q) begin
          clr = 1'b1;
          tin = 1'b1;
          mib = (off_q != last_off) ? wdata_q[off_q] : 1'b0;
        end else begin
          tout = 1'b1;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request latch, transfer offset, read capture and read-data update.
  always_ff @(posedge r1_clk or negedge r1_rst_n) begin
    if (!r1_rst_n) begin
      we_q    <= 1'b0;
      long_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      rd_sh_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.r1_we;
        long_q  <= bus.r1_long;
        addr_q  <= addr_in;
        wdata_q <= bus.r1_wdata;
        rd_sh_q <= '0;
      end
      off_q <= (state_q == XFER) ? off_q + 1'b1 : '0;
      // Gap pulse (last offset) carries no data and is not captured.
      if (state_q == XFER && !we_q && off_q != last_off)
        rd_sh_q[off_q] <= bus.r1_mob;
      if (xfer_last && !we_q)
        rdata_q <= long_q ? rd_sh_q : WORD_W'(rd_sh_q[SW-1:0]);
    end
  end

  assign bus.r1_ack      = (state_q == DONE);
  assign bus.r1_busy     = (state_q != IDLE);
  assign bus.r1_rdata    = rdata_q;
  assign bus.r1_tank_clr = clr;
  assign bus.r1_tank_in  = tin;
  assign bus.r1_tank_out = tout;
  assign bus.r1_mib      = mib;
  assign bus.r1_pulse    = pulse_q;
  assign bus.r1_minor    = minor_q;
endmodule

// File: tb/tb_memory_tank_access.sv
// Directed bench for memory_tank_access with a 576-bit circulating tank model.
// Expected serial bits and read data are queued when a request is issued and
// consumed when the DUT drives the tank or acknowledges.
module tb_memory_tank_access;
  localparam int W    = 35;
  localparam int CIRC = 576;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cnt;
  bit   tank [CIRC];
  bit   mib_q [$];
  logic [W-1:0] rd_q [$];

  memory_tank_access_if #(.WORD_W(W)) bus();

  memory_tank_access #(.PULSES(18), .MINORS(32), .WORD_W(W)) dut (
    .r1_clk  (clk),
    .r1_rst_n(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Bench-owned pulse-time counter since last reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 0;
    else        cnt <= cnt + 1;

  // Tank: written through the input gate, read through the output gate.
  always @(posedge clk)
    if (rst_n && bus.r1_tank_in) tank[cnt % CIRC] <= bus.r1_mib;

  assign bus.r1_mob = bus.r1_tank_out ? tank[cnt % CIRC] : 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial write stream checked against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.r1_tank_in) begin
      bit e;
      chk("clr_with_in", 64'(bus.r1_tank_clr), 64'd1);
      if (mib_q.size() == 0) chk("mib_extra", 64'(bus.r1_tank_in), 64'd0);
      else begin
        e = mib_q.pop_front();
        chk("mib", 64'(bus.r1_mib), 64'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while ((cnt % CIRC) != p && n < CIRC + 2) begin
      step();
      n++;
    end
  endtask

  task automatic issue(input bit we, input bit lng, input logic [4:0] a,
                       input logic [W-1:0] d);
    bus.r1_req   = 1'b1;
    bus.r1_we    = we;
    bus.r1_long  = lng;
    bus.r1_addr  = a;
    bus.r1_wdata = d;
    if (we) begin
      int L = lng ? 36 : 18;
      for (int k = 0; k < L; k++) mib_q.push_back((k < L - 1) ? d[k] : 1'b0);
    end
    step();
    bus.r1_req = 1'b0;
  endtask

  // lat counts samples from the accept edge; poke raises r1_req for one cycle.
  task automatic wait_ack(input int poke, output int lat, output int n_in,
                          output int n_out, output int first);
    lat = 1; n_in = 0; n_out = 0; first = -1;
    while (1) begin
      if ((bus.r1_tank_in || bus.r1_tank_out) && first < 0) first = cnt % CIRC;
      n_in  += int'(bus.r1_tank_in);
      n_out += int'(bus.r1_tank_out);
      if (bus.r1_ack || lat >= 800) break;
      bus.r1_req = (lat == poke);
      step();
      lat++;
    end
    bus.r1_req = 1'b0;
    chk("ack_seen", 64'(bus.r1_ack), 64'd1);
  endtask

  initial begin
    int lat, n_in, n_out, first, bad, wrap_at, maxp, maxm, nb;
    logic [W-1:0] exp_rd;
    logic [W-1:0] lw;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_long = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
    for (int i = 0; i < CIRC; i++) tank[i] = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", 64'(bus.r1_pulse), 64'd0);
    chk("rst_minor", 64'(bus.r1_minor), 64'd0);
    chk("rst_ack",   64'(bus.r1_ack),   64'd0);
    chk("rst_busy",  64'(bus.r1_busy),  64'd0);
    chk("rst_rdata", 64'(bus.r1_rdata), 64'd0);
    chk("rst_gates", 64'({bus.r1_tank_clr, bus.r1_tank_in, bus.r1_tank_out, bus.r1_mib}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Free-running counters over 1200 cycles
    bad = 0; wrap_at = -1; maxp = 0; maxm = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (bus.r1_pulse != 5'(cnt % 18) || bus.r1_minor != 5'((cnt / 18) % 32) ||
          bus.r1_tank_clr || bus.r1_tank_in || bus.r1_tank_out || bus.r1_mib) bad++;
      if (wrap_at < 0 && bus.r1_pulse == 5'd0 && bus.r1_minor == 5'd0) wrap_at = cnt;
      if (int'(bus.r1_pulse) > maxp) maxp = int'(bus.r1_pulse);
      if (int'(bus.r1_minor) > maxm) maxm = int'(bus.r1_minor);
    end
    chk("cnt_bad_cycles", 64'(bad), 64'd0);
    chk("minor_wrap_at", 64'(wrap_at), 64'd576);
    chk("pulse_max", 64'(maxp), 64'd17);
    chk("minor_max", 64'(maxm), 64'd31);

    // Short write addr 5 requested at (0,3)
    wait_pos(3);
    issue(1'b1, 1'b0, 5'd5, 35'h1A5A5);
    wait_ack(-1, lat, n_in, n_out, first);
    chk("sw_first", 64'(first), 64'(5 * 18));
    chk("sw_n_in", 64'(n_in), 64'd18);
    chk("sw_n_out", 64'(n_out), 64'd0);
    chk("sw_ack_pos", 64'(cnt % CIRC), 64'(6 * 18));
    chk("sw_rdata_kept", 64'(bus.r1_rdata), 64'd0);
    step();

    // Short read addr 5
    rd_q.push_back(35'h001A5A5);
    issue(1'b0, 1'b0, 5'd5, 35'h7_FFFF_FFFF);
    wait_ack(-1, lat, n_in, n_out, first);
    exp_rd = rd_q.pop_front();
    chk("sr_rdata", 64'(bus.r1_rdata), 64'(exp_rd));
    chk("sr_first", 64'(first), 64'(5 * 18));
    chk("sr_n_out", 64'(n_out), 64'd18);
    chk("sr_n_in", 64'(n_in), 64'd0);
    chk("sr_lat_max", 64'(lat <= 576 + 18 + 1), 64'd1);
    repeat (3) step();
    chk("sr_rdata_hold", 64'(bus.r1_rdata), 64'(exp_rd));

    // Long write addr 7 (even pair at 6)
    lw = 35'h5_5555_5555;
    issue(1'b1, 1'b1, 5'd7, lw);
    wait_ack(-1, lat, n_in, n_out, first);
    chk("lw_first", 64'(first), 64'(6 * 18));
    chk("lw_n_in", 64'(n_in), 64'd36);
    chk("lw_sandwich", 64'(tank[6 * 18 + 17]), 64'(lw[17]));
    chk("lw_bit18", 64'(tank[7 * 18]), 64'(lw[18]));
    chk("lw_gap", 64'(tank[7 * 18 + 17]), 64'd0);
    step();

    // Long read addr 7
    rd_q.push_back(35'h5_5555_5555);
    issue(1'b0, 1'b1, 5'd7, 35'h0);
    wait_ack(-1, lat, n_in, n_out, first);
    exp_rd = rd_q.pop_front();
    chk("lr_rdata", 64'(bus.r1_rdata), 64'(exp_rd));
    chk("lr_first", 64'(first), 64'(6 * 18));
    chk("lr_n_out", 64'(n_out), 64'd36);
    step();

    // Accept edge coincides with (3,0); a request during XFER is ignored
    wait_pos(2 * 18 + 17);
    issue(1'b1, 1'b0, 5'd3, 35'h0F0F3);
    bus.r1_addr = 5'd4;
    wait_ack(5, lat, n_in, n_out, first);
    chk("sim_lat", 64'(lat), 64'd19);
    chk("sim_first", 64'(first), 64'(3 * 18));
    chk("sim_n_in", 64'(n_in), 64'd18);
    nb = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      nb += int'(bus.r1_busy);
    end
    chk("sim_no_requeue", 64'(nb), 64'd0);

    // Reset at offset 9 of a write
    issue(1'b1, 1'b0, 5'd10, 35'h1FFFF);
    nb = 0;
    while (!bus.r1_tank_in && nb < 700) begin step(); nb++; end
    chk("rw_started", 64'(bus.r1_tank_in), 64'd1);
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("rw_gates_async", 64'({bus.r1_tank_clr, bus.r1_tank_in, bus.r1_tank_out, bus.r1_mib}), 64'd0);
    chk("rw_ack_busy", 64'({bus.r1_ack, bus.r1_busy}), 64'd0);
    mib_q.delete();
    step();
    chk("rw_rdata", 64'(bus.r1_rdata), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rw_pos_release", 64'({bus.r1_minor, bus.r1_pulse}), 64'd0);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      nb += int'(bus.r1_ack);
    end
    chk("rw_no_ack", 64'(nb), 64'd0);
    chk("rw_pulse_after", 64'(bus.r1_pulse), 64'(cnt % 18));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
